mem_dump_reader: RTL and testbench

Sequential read-back engine for the single-cycle ARM system's data memory. After the processor halts, a `start` pulse makes it walk a window of `dmem` word by word on the read port. For each word it converts the address and data to BCD and holds them on the four digit outputs, which feed the existing seven-segment decoders, for a programmable dwell time. It also flags whether the expected result word (address 100, value 7) was found during the sweep.

---
 rtl/mem_dump_reader.sv | 187 ++++++++++++++++++
 tb/tb_mem_dump_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Walks a window of data memory after halt, showing each word's address
// and data as BCD on four digit outputs for a programmable dwell time.
//
// Ports:
//   clk, reset (async, active-low), start (1-cycle pulse)
//   rd_addr / rd_data : dmem read port
//   busy, done        : dump in progress / dump finished
//   match             : sticky, MATCH_DATA seen at MATCH_ADDR
//   dig0..dig2        : BCD units/tens/hundreds of rd_addr mod 1000
//   dig3              : BCD units of rd_data
module mem_dump_reader #(
  parameter logic [31:0] START_ADDR = 32'd0,
  parameter int unsigned WORD_COUNT = 32,
  parameter int unsigned DWELL      = 50_000_000,
  parameter logic [31:0] MATCH_ADDR = 32'd100,
  parameter logic [31:0] MATCH_DATA = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CONV_A = 3'd3;
  localparam logic [2:0] S_CONV_D = 3'd4;
  localparam logic [2:0] S_DWELL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dwell_q, dwell_d;
  logic [31:0] data_q, data_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  bit_q, bit_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] abcd_q, abcd_d;
  logic [15:0] dig_q, dig_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic [11:0] step;

  // Only three BCD nibbles are kept: dropping the carry out of the
  // hundreds nibble yields exactly the value mod 1000.
  function automatic logic [11:0] dd_step(
    input logic [11:0] b,
    input logic        in
  );
    logic [11:0] c;
    for (int i = 0; i < 3; i++) begin
      c[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ?
                    b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return {c[10:0], in};
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    data_d  = data_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    bcd_d   = bcd_q;
    abcd_d  = abcd_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    step    = dd_step(bcd_q, shift_q[31]);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ADDR;
          addr_d  = START_ADDR;
          cnt_d   = '0;
          match_d = 1'b0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_ADDR: state_d = S_SAMPLE;
      S_SAMPLE: begin
        data_d = rd_data;
        if (addr_q == MATCH_ADDR && rd_data == MATCH_DATA)
          match_d = 1'b1;
        shift_d = addr_q;
        bcd_d   = '0;
        bit_d   = '0;
        state_d = S_CONV_A;
      end
      S_CONV_A: begin
        bcd_d   = step;
        shift_d = shift_q << 1;
        bit_d   = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          abcd_d  = step;
          shift_d = data_q;
          bcd_d   = '0;
          state_d = S_CONV_D;
        end
      end
      S_CONV_D: begin
        bcd_d   = step;
        shift_d = shift_q << 1;
        bit_d   = bit_q + 5'd1;
        if (bit_q == 5'd31) begin
          // all four digits change together, never mid-conversion
          dig_d   = {step[3:0], abcd_q};
          dwell_d = '0;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        dwell_d = dwell_q + 32'd1;
        if (dwell_q == DWELL - 1) begin
          dwell_d = '0;
          cnt_d   = cnt_q + 32'd1;
          if (cnt_q + 32'd1 == WORD_COUNT) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 32'd4;
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= START_ADDR;
      cnt_q   <= '0;
      dwell_q <= '0;
      data_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      abcd_q  <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      bcd_q   <= bcd_d;
      abcd_q  <= abcd_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign match   = match_q;
  assign dig0    = dig_q[3:0];
  assign dig1    = dig_q[7:4];
  assign dig2    = dig_q[11:8];
  assign dig3    = dig_q[15:12];

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: three instances with
// different windows share one behavioural memory.
module tb_mem_dump_reader;

  localparam int P = 70;
  localparam logic [31:0] SA [3] = '{32'd96, 32'd0, 32'hFFFF_FFFC};
  localparam int WC [3] = '{3, 4, 2};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] start = '0;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] rdata;
  logic [2:0] busy, done, match;
  logic [2:0][15:0] dig;
  logic [31:0] mem [64];
  logic [15:0] prev [3];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) rdata[i] = mem[addr[i][7:2]];
  end

  mem_dump_reader #(.START_ADDR(32'd96), .WORD_COUNT(3), .DWELL(4)) u_a (
    .clk(clk), .reset(reset), .start(start[0]),
    .rd_addr(addr[0]), .rd_data(rdata[0]),
    .busy(busy[0]), .done(done[0]), .match(match[0]),
    .dig0(dig[0][3:0]), .dig1(dig[0][7:4]),
    .dig2(dig[0][11:8]), .dig3(dig[0][15:12]));

  mem_dump_reader #(.START_ADDR(32'd0), .WORD_COUNT(4), .DWELL(4)) u_b (
    .clk(clk), .reset(reset), .start(start[1]),
    .rd_addr(addr[1]), .rd_data(rdata[1]),
    .busy(busy[1]), .done(done[1]), .match(match[1]),
    .dig0(dig[1][3:0]), .dig1(dig[1][7:4]),
    .dig2(dig[1][11:8]), .dig3(dig[1][15:12]));

  mem_dump_reader #(.START_ADDR(32'hFFFF_FFFC), .WORD_COUNT(2),
                    .DWELL(4)) u_c (
    .clk(clk), .reset(reset), .start(start[2]),
    .rd_addr(addr[2]), .rd_data(rdata[2]),
    .busy(busy[2]), .done(done[2]), .match(match[2]),
    .dig0(dig[2][3:0]), .dig1(dig[2][7:4]),
    .dig2(dig[2][11:8]), .dig3(dig[2][15:12]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_dig(input logic [31:0] a,
                                          input logic [31:0] d);
    return {4'(d % 10), 4'((a / 100) % 10),
            4'((a / 10) % 10), 4'(a % 10)};
  endfunction

  task automatic run(input int id);
    int n;
    int w;
    int k;
    logic [31:0] a;
    logic exp_m;
    logic exp_prev_m;
    n = WC[id];
    exp_m = 1'b0;
    exp_prev_m = 1'b0;
    start[id] = 1'b1;
    @(posedge clk);
    #1;
    start[id] = 1'b0;
    for (int c = 0; c <= n * P; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      w = c / P;
      k = c % P;
      a = SA[id] + 32'(4 * w);
      if (c == 0) begin
        check("busy_rise", 32'(busy[id]), 1);
        check("done_clr", 32'(done[id]), 0);
        check("match_clr", 32'(match[id]), 0);
      end
      if (w < n && k == 0) check("rd_addr", addr[id], a);
      if (w < n && k == 1) begin
        exp_prev_m = exp_m;
        check("match_early", 32'(match[id]), 32'(exp_prev_m));
      end
      if (w < n && k == 2) begin
        if (a == 32'd100 && mem[a[7:2]] == 32'd7) exp_m = 1'b1;
        check("match", 32'(match[id]), 32'(exp_m));
      end
      if (w < n && k == 65) check("dig_hold", 32'(dig[id]), 32'(prev[id]));
      if (w < n && k == 66) begin
        prev[id] = exp_dig(a, mem[a[7:2]]);
        check("digits", 32'(dig[id]), 32'(prev[id]));
      end
      if (c == n * P - 1) begin
        check("busy_last", 32'(busy[id]), 1);
        check("done_early", 32'(done[id]), 0);
      end
      if (c == n * P) begin
        check("done_set", 32'(done[id]), 1);
        check("busy_fall", 32'(busy[id]), 0);
        check("match_end", 32'(match[id]), 32'(exp_m));
        check("dig_keep", 32'(dig[id]), 32'(prev[id]));
      end
      // stray start pulses while busy must change nothing
      start[id] = (c % 37 == 5 && c < n * P - 2) ? 1'b1 : 1'b0;
    end
    start[id] = 1'b0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    for (int i = 0; i < 3; i++) prev[i] = '0;
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_addr", addr[i], SA[i]);
      check("rst_flags", 32'({busy[i], done[i], match[i]}), 0);
      check("rst_dig", 32'(dig[i]), 0);
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    run(1);

    rand_mem();
    mem[25] = 32'd7;
    run(0);
    mem[25] = 32'd6;
    run(0);
    mem[25] = 32'd7;
    run(0);

    rand_mem();
    run(2);

    for (int r = 0; r < 4; r++) begin
      rand_mem();
      mem[25] = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'd6;
      run(r % 3);
    end

    // asynchronous reset during the dwell of the third word
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (2 * P + 67) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy[1]), 0);
    check("arst_dig", 32'(dig[1]), 0);
    check("arst_addr", addr[1], 32'd0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy[1]), 0);
    check("idle_done", 32'(done[1]), 0);
    check("idle_addr", addr[1], 32'd0);
    for (int i = 0; i < 3; i++) prev[i] = '0;

    rand_mem();
    run(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
